// File: rtl/cpu_pkg.sv
// Shared opcode and state encodings for the accumulator core and its ALU.
package cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_LDR  = 4'h2;
    localparam logic [3:0] OP_STR  = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_SHL  = 4'h9;
    localparam logic [3:0] OP_SHR  = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_JZ   = 4'hC;
    localparam logic [3:0] OP_JC   = 4'hD;
    localparam logic [3:0] OP_ADDI = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    // Ops whose result lands in the accumulator (and therefore update Z).
    function automatic logic writes_acc(input logic [3:0] op);
        case (op)
            OP_LDI, OP_LDR, OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_SHL, OP_SHR, OP_ADDI: writes_acc = 1'b1;
            default:                         writes_acc = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU. Carry passes through from cin for ops that leave C alone,
// and y defaults to a, so the core can latch cout unconditionally in EXEC.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic [DATA_W-1:0] y,
    output logic              cout,
    output logic              z
);

    logic [DATA_W:0] sum;

    always_comb begin
        sum  = {1'b0, a} + {1'b0, b};
        y    = a;
        cout = cin;
        case (op)
            OP_LDI, OP_LDR: y = b;
            OP_ADD, OP_ADDI: begin
                y    = sum[DATA_W-1:0];
                cout = sum[DATA_W];
            end
            OP_SUB: begin
                y    = a - b;
                cout = (a < b);
            end
            OP_AND: begin
                y    = a & b;
                cout = 1'b0;
            end
            OP_OR: begin
                y    = a | b;
                cout = 1'b0;
            end
            OP_XOR: begin
                y    = a ^ b;
                cout = 1'b0;
            end
            OP_SHL: begin
                y    = {a[DATA_W-2:0], 1'b0};
                cout = a[DATA_W-1];
            end
            OP_SHR: begin
                y    = {1'b0, a[DATA_W-1:1]};
                cout = a[0];
            end
            default: ;
        endcase
        z = (y == '0);
    end

endmodule

// File: rtl/acc_cpu_core.sv
// Accumulator CPU core: fetch/decode/exec controller, PC, register file,
// accumulator and flags around a combinational ALU.
//
//   state     | meaning
//   ----------+---------------------------------------------------
//   ST_IDLE   | after reset, waiting for run
//   ST_FETCH  | imem_req high at pc, waiting for imem_ack
//   ST_DECODE | ir valid, pc advances
//   ST_EXEC   | ALU result / store / jump committed
//   ST_HALT   | stopped after HLT, run resumes at pc
module acc_cpu_core
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int OPND_W = 4
) (
    input  logic                CLK,
    input  logic                CLB,
    input  logic                run,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_ack,
    input  logic [OPND_W+3:0]   imem_rdata,
    output logic [ADDR_W-1:0]   pc_out,
    output logic [DATA_W-1:0]   acc_out,
    output logic                flag_z,
    output logic                flag_c,
    output logic                halted
);

    localparam int INSTR_W   = 4 + OPND_W;
    localparam int REG_DEPTH = 2 ** OPND_W;

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   pc;
    logic [DATA_W-1:0]   acc;
    logic [INSTR_W-1:0]  ir;
    logic [DATA_W-1:0]   regs [REG_DEPTH];
    logic                zf, cf;

    logic [3:0]          opcode;
    logic [OPND_W-1:0]   opnd;
    logic [DATA_W-1:0]   reg_rd;
    logic [DATA_W-1:0]   alu_b;
    logic [DATA_W-1:0]   alu_y;
    logic                alu_cout, alu_z;
    logic                jump_taken;

    assign opcode = ir[INSTR_W-1 -: 4];
    assign opnd   = ir[OPND_W-1:0];
    assign reg_rd = regs[opnd];
    assign alu_b  = (opcode == OP_LDI || opcode == OP_ADDI) ? DATA_W'(opnd) : reg_rd;

    assign jump_taken = (opcode == OP_JMP) ||
                        (opcode == OP_JZ && zf) ||
                        (opcode == OP_JC && cf);

    cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .op   (opcode),
        .a    (acc),
        .b    (alu_b),
        .cin  (cf),
        .y    (alu_y),
        .cout (alu_cout),
        .z    (alu_z)
    );

    always_ff @(posedge CLK or posedge CLB) begin
        if (CLB) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        imem_req = 1'b0;
        halted   = 1'b0;
        case (state)
            ST_IDLE:   if (run) state_nx = ST_FETCH;
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) state_nx = ST_DECODE;
            end
            ST_DECODE: state_nx = ST_EXEC;
            ST_EXEC:   state_nx = (opcode == OP_HLT) ? ST_HALT : ST_FETCH;
            ST_HALT: begin
                halted = 1'b1;
                if (run) state_nx = ST_FETCH;
            end
            default:   state_nx = ST_IDLE;
        endcase
    end

    // Every architectural write is gated by state, so an async reset in any
    // state leaves nothing half-committed.
    always_ff @(posedge CLK or posedge CLB) begin
        if (CLB) begin
            pc  <= '0;
            acc <= '0;
            ir  <= '0;
            zf  <= 1'b0;
            cf  <= 1'b0;
            for (int i = 0; i < REG_DEPTH; i++) regs[i] <= '0;
        end else begin
            case (state)
                ST_FETCH:  if (imem_ack) ir <= imem_rdata;
                ST_DECODE: pc <= pc + ADDR_W'(1);
                ST_EXEC: begin
                    if (jump_taken) pc <= reg_rd[ADDR_W-1:0];
                    if (writes_acc(opcode)) begin
                        acc <= alu_y;
                        zf  <= alu_z;
                    end
                    cf <= alu_cout;
                    if (opcode == OP_STR) regs[opnd] <= acc;
                end
                default: ;
            endcase
        end
    end

    assign imem_addr = pc;
    assign pc_out    = pc;
    assign acc_out   = acc;
    assign flag_z    = zf;
    assign flag_c    = cf;

endmodule

// File: tb/tb_acc_cpu_core.sv
// Directed bench for acc_cpu_core with a behavioural ROM and wait-state ack generator.
module tb_acc_cpu_core;

    logic       CLK = 1'b0;
    logic       CLB = 1'b1;
    logic       run = 1'b0;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_rdata;
    logic [7:0] pc_out;
    logic [7:0] acc_out;
    logic       flag_z, flag_c, halted;

    logic [7:0] rom [256];
    int         wait_n    = 0;
    int         wcnt      = 0;
    logic       ack_en    = 1'b1;
    logic       force_ack = 1'b0;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    always #5 CLK = ~CLK;

    acc_cpu_core dut (
        .CLK        (CLK),
        .CLB        (CLB),
        .run        (run),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pc_out     (pc_out),
        .acc_out    (acc_out),
        .flag_z     (flag_z),
        .flag_c     (flag_c),
        .halted     (halted)
    );

    assign imem_rdata = rom[imem_addr];
    assign imem_ack   = force_ack | (ack_en & imem_req & (wcnt >= wait_n));

    always @(posedge CLK or posedge CLB) begin
        if (CLB)                       wcnt <= 0;
        else if (imem_req && !imem_ack) wcnt <= wcnt + 1;
        else                           wcnt <= 0;
    end

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 256; i++) rom[i] = v;
    endtask

    task automatic do_reset();
        CLB = 1'b1; run = 1'b0; force_ack = 1'b0; ack_en = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        CLB = 1'b0;
    endtask

    // Pulse run; cyc counts clock edges after the one that leaves IDLE/HALT.
    task automatic run_to_halt(input int budget, output int cyc);
        @(negedge CLK); run = 1'b1;
        @(negedge CLK); run = 1'b0;
        cyc = 0;
        while (!halted && cyc < budget) begin
            @(negedge CLK);
            cyc++;
        end
    endtask

    task automatic load_prog1();
        fill(8'hF0);
        rom[0] = 8'h15; rom[1] = 8'hE3; rom[2] = 8'hF0;
    endtask

    task automatic test_reset();
        int cyc;
        do_reset();
        chk_cnt++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %b exp 0", imem_req); else pass_cnt++;
        chk_cnt++; if (halted !== 1'b0) $display("FAIL rst_halted: got %b exp 0", halted); else pass_cnt++;
        chk_cnt++; if (pc_out !== 8'h00) $display("FAIL rst_pc: got %h exp 00", pc_out); else pass_cnt++;
        chk_cnt++; if (acc_out !== 8'h00) $display("FAIL rst_acc: got %h exp 00", acc_out); else pass_cnt++;
        chk_cnt++; if ({flag_z, flag_c} !== 2'b00) $display("FAIL rst_flags: got %b exp 00", {flag_z, flag_c}); else pass_cnt++;
        wait_n = 0;
        load_prog1();
        run_to_halt(50, cyc);
        chk_cnt++; if (halted !== 1'b1) $display("FAIL t1_halted: got %b exp 1", halted); else pass_cnt++;
        chk_cnt++; if (cyc !== 9) $display("FAIL t1_cycles: got %0d exp 9", cyc); else pass_cnt++;
        chk_cnt++; if (acc_out !== 8'h08) $display("FAIL t1_acc: got %h exp 08", acc_out); else pass_cnt++;
        chk_cnt++; if ({flag_z, flag_c} !== 2'b00) $display("FAIL t1_flags: got %b exp 00", {flag_z, flag_c}); else pass_cnt++;
        chk_cnt++; if (pc_out !== 8'h03) $display("FAIL t1_pc: got %h exp 03", pc_out); else pass_cnt++;
    endtask

    task automatic test_wait_states();
        int         cyc, req_cycles;
        logic       unstable, in_fetch;
        logic [7:0] prev_addr;
        do_reset();
        wait_n = 4;
        load_prog1();
        @(negedge CLK); run = 1'b1;
        @(negedge CLK); run = 1'b0;
        cyc = 0; req_cycles = 0; unstable = 1'b0; in_fetch = 1'b0; prev_addr = 8'h00;
        while (!halted && cyc < 100) begin
            if (imem_req) begin
                req_cycles++;
                if (in_fetch && imem_addr !== prev_addr) unstable = 1'b1;
                if (imem_addr !== pc_out) unstable = 1'b1;
                prev_addr = imem_addr;
                in_fetch  = 1'b1;
            end else begin
                in_fetch = 1'b0;
            end
            @(negedge CLK);
            cyc++;
        end
        chk_cnt++; if (cyc !== 21) $display("FAIL t2_cycles: got %0d exp 21", cyc); else pass_cnt++;
        chk_cnt++; if (req_cycles !== 15) $display("FAIL t2_req_cycles: got %0d exp 15", req_cycles); else pass_cnt++;
        chk_cnt++; if (unstable !== 1'b0) $display("FAIL t2_addr_stable: got %b exp 0", unstable); else pass_cnt++;
        chk_cnt++; if ({acc_out, pc_out} !== 16'h0803) $display("FAIL t2_state: got acc=%h pc=%h exp acc=08 pc=03", acc_out, pc_out); else pass_cnt++;
        wait_n = 0;
    endtask

    task automatic test_carry_borrow();
        int cyc;
        do_reset();
        fill(8'hF0);
        rom[0] = 8'h1F; rom[1] = 8'h31;
        rom[2] = 8'h90; rom[3] = 8'h90; rom[4] = 8'h90; rom[5] = 8'h90;
        rom[6] = 8'h41; rom[7] = 8'hF0;
        rom[8] = 8'hE1; rom[9] = 8'hF0;
        rom[10] = 8'h10; rom[11] = 8'h51; rom[12] = 8'hF0;
        run_to_halt(100, cyc);
        chk_cnt++; if ({acc_out, flag_c, flag_z} !== {8'hFF, 2'b00}) $display("FAIL t3_add: got acc=%h c=%b z=%b exp acc=ff c=0 z=0", acc_out, flag_c, flag_z); else pass_cnt++;
        chk_cnt++; if (pc_out !== 8'h08) $display("FAIL t3_pc1: got %h exp 08", pc_out); else pass_cnt++;
        run_to_halt(50, cyc);
        chk_cnt++; if ({acc_out, flag_c, flag_z} !== {8'h00, 2'b11}) $display("FAIL t3_addi_wrap: got acc=%h c=%b z=%b exp acc=00 c=1 z=1", acc_out, flag_c, flag_z); else pass_cnt++;
        run_to_halt(50, cyc);
        chk_cnt++; if ({acc_out, flag_c, flag_z} !== {8'hF1, 2'b10}) $display("FAIL t3_sub_borrow: got acc=%h c=%b z=%b exp acc=f1 c=1 z=0", acc_out, flag_c, flag_z); else pass_cnt++;
        chk_cnt++; if (pc_out !== 8'h0D) $display("FAIL t3_pc3: got %h exp 0d", pc_out); else pass_cnt++;
    endtask

    task automatic test_branches();
        int cyc;
        do_reset();
        fill(8'hF0);
        rom[0] = 8'h1A; rom[1] = 8'h32; rom[2] = 8'h10; rom[3] = 8'hC2;
        rom[8'h0B] = 8'hD2; rom[8'h0C] = 8'hF0;
        rom[8'h0D] = 8'h1F; rom[8'h0E] = 8'hA0; rom[8'h0F] = 8'hD2;
        run_to_halt(100, cyc);
        chk_cnt++; if ({pc_out, flag_z} !== {8'h0B, 1'b1}) $display("FAIL t4_jz_taken: got pc=%h z=%b exp pc=0b z=1", pc_out, flag_z); else pass_cnt++;
        run_to_halt(50, cyc);
        chk_cnt++; if (pc_out !== 8'h0D) $display("FAIL t4_jc_not_taken: got pc=%h exp 0d", pc_out); else pass_cnt++;
        run_to_halt(50, cyc);
        chk_cnt++; if ({pc_out, acc_out, flag_c} !== {8'h0B, 8'h07, 1'b1}) $display("FAIL t4_jc_taken: got pc=%h acc=%h c=%b exp pc=0b acc=07 c=1", pc_out, acc_out, flag_c); else pass_cnt++;
    endtask

    task automatic test_pc_wrap();
        int cyc;
        do_reset();
        fill(8'h00);
        rom[8'hFE] = 8'hF0;
        run_to_halt(1000, cyc);
        chk_cnt++; if ({halted, pc_out} !== {1'b1, 8'hFF}) $display("FAIL t5_pc_ff: got halted=%b pc=%h exp halted=1 pc=ff", halted, pc_out); else pass_cnt++;
        rom[8'h00] = 8'hF0;
        @(negedge CLK); run = 1'b1;
        @(negedge CLK); run = 1'b0;
        chk_cnt++; if ({imem_req, imem_addr} !== {1'b1, 8'hFF}) $display("FAIL t5_fetch_ff: got req=%b addr=%h exp req=1 addr=ff", imem_req, imem_addr); else pass_cnt++;
        repeat (3) @(negedge CLK);
        chk_cnt++; if ({imem_req, imem_addr} !== {1'b1, 8'h00}) $display("FAIL t5_fetch_wrap: got req=%b addr=%h exp req=1 addr=00", imem_req, imem_addr); else pass_cnt++;
        cyc = 0;
        while (!halted && cyc < 20) begin
            @(negedge CLK);
            cyc++;
        end
        chk_cnt++; if ({halted, pc_out} !== {1'b1, 8'h01}) $display("FAIL t5_halt_after_wrap: got halted=%b pc=%h exp halted=1 pc=01", halted, pc_out); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        int cyc;
        do_reset();
        fill(8'h15);
        ack_en = 1'b0;
        @(negedge CLK); run = 1'b1;
        @(negedge CLK); run = 1'b0;
        repeat (3) @(negedge CLK);
        chk_cnt++; if (imem_req !== 1'b1) $display("FAIL t6_req_waiting: got %b exp 1", imem_req); else pass_cnt++;
        #2 CLB = 1'b1;
        #1;
        chk_cnt++; if (imem_req !== 1'b0) $display("FAIL t6_req_drop: got %b exp 0", imem_req); else pass_cnt++;
        @(negedge CLK); CLB = 1'b0; force_ack = 1'b1; ack_en = 1'b1;
        repeat (4) @(negedge CLK);
        chk_cnt++; if ({imem_req, pc_out, acc_out} !== {1'b0, 8'h00, 8'h00}) $display("FAIL t6_late_ack: got req=%b pc=%h acc=%h exp req=0 pc=00 acc=00", imem_req, pc_out, acc_out); else pass_cnt++;
        force_ack = 1'b0;
        @(negedge CLK); run = 1'b1;
        @(negedge CLK); run = 1'b0;
        chk_cnt++; if (imem_req !== 1'b1) $display("FAIL t6_restart: got req=%b exp 1", imem_req); else pass_cnt++;

        do_reset();
        fill(8'hF0);
        rom[0] = 8'h1F; rom[1] = 8'h31;
        @(negedge CLK); run = 1'b1;
        @(negedge CLK); run = 1'b0;
        repeat (5) @(negedge CLK);
        chk_cnt++; if (acc_out !== 8'h0F) $display("FAIL t6_pre_str_acc: got %h exp 0f", acc_out); else pass_cnt++;
        #1 CLB = 1'b1;
        #1;
        chk_cnt++; if ({imem_req, acc_out, halted} !== {1'b0, 8'h00, 1'b0}) $display("FAIL t6_exec_reset: got req=%b acc=%h halted=%b exp req=0 acc=00 halted=0", imem_req, acc_out, halted); else pass_cnt++;
        @(negedge CLK); CLB = 1'b0;
        rom[0] = 8'h21; rom[1] = 8'hF0;
        run_to_halt(50, cyc);
        chk_cnt++; if ({halted, acc_out, flag_z, pc_out} !== {1'b1, 8'h00, 1'b1, 8'h02}) $display("FAIL t6_r1_unchanged: got halted=%b acc=%h z=%b pc=%h exp halted=1 acc=00 z=1 pc=02", halted, acc_out, flag_z, pc_out); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_wait_states();
        test_carry_borrow();
        test_branches();
        test_pc_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
